// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 7-segment display driver.
// Generates its own scan tick from clk_m and walks the digits left to right.
// On each tick it loads the decoded segment pattern for the new digit.
// The anodes stay dark for a short guard window after every digit switch.
// Supports per-digit decimal point, blanking and blinking, plus hex or dash
// display of values 10-15.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned GUARD_CYC  = 2,
  parameter int unsigned BLINK_DIV  = 250
) (
  input  logic                          clk_m,
  input  logic                          rst_n,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         blank_in,
  input  logic [NUM_DIGITS-1:0]         blink_in,
  input  logic                          hex_mode,
  output logic [NUM_DIGITS-1:0]         an_d,
  output logic [7:0]                    seg_d,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_sel
);

  localparam int unsigned SEL_W   = $clog2(NUM_DIGITS);
  localparam int unsigned PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned GUARD_W = (GUARD_CYC > 0) ? $clog2(GUARD_CYC + 1) : 1;
  localparam int unsigned FRAME_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SEL_W-1:0]   LAST_DIG   = SEL_W'(NUM_DIGITS - 1);
  localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(SCAN_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_MAX  = FRAME_W'(BLINK_DIV - 1);
  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYC);
  localparam bit                 NO_GUARD   = (GUARD_CYC == 0);
  localparam logic [7:0]         SEG_DARK   = 8'hFF;

  // ST_DARK: after reset, before the first tick; ST_GUARD: anodes held off
  // after a switch; ST_DRIVE: selected anode on until the next tick.
  typedef enum logic [1:0] {
    ST_DARK  = 2'd0,
    ST_GUARD = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

  scan_state_t            state_q, state_nxt;
  logic [PRESC_W-1:0]     presc_q, presc_nxt;
  logic [FRAME_W-1:0]     frame_q, frame_nxt;
  logic [GUARD_W-1:0]     guard_q, guard_nxt;
  logic                   blink_phase_q, blink_phase_nxt;
  logic [SEL_W-1:0]       sel_nxt;
  logic [NUM_DIGITS-1:0]  an_nxt;
  logic [7:0]             seg_nxt;

  logic                   tick_c;
  logic                   wrap_c;
  logic [SEL_W-1:0]       sel_next_c;
  logic [3:0]             dig_val [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]  dp_ord, blank_ord, blink_ord;
  logic [NUM_DIGITS-1:0]  an_tick_c, an_cur_c;
  logic [3:0]             slot_val_c;
  logic                   slot_dp_c, slot_blank_c, slot_blink_c;
  logic [7:0]             slot_pat_c;

  // Segment decode, G..A, active low. Values 10-15 show a dash unless hex is on.
  function automatic logic [6:0] seg7_decode(input logic [3:0] v, input logic hex);
    logic [6:0] g;
    case (v)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      4'hF:    g = 7'h0E;
      default: g = 7'h3F;
    endcase
    if (!hex && (v > 4'd9)) g = 7'h3F;
    return g;
  endfunction

  // Scan tick and frame wrap detection.
  assign tick_c     = (presc_q == PRESC_MAX);
  assign wrap_c     = (digit_sel == LAST_DIG);
  assign sel_next_c = wrap_c ? '0 : digit_sel + SEL_W'(1);

  // Reorder the per-digit inputs so index i addresses digit i (leftmost = 0),
  // and build the anode masks for the next and the current digit.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    assign dig_val[g]                   = digits_in[4*(NUM_DIGITS-1-g) +: 4];
    assign dp_ord[g]                    = dp_in[NUM_DIGITS-1-g];
    assign blank_ord[g]                 = blank_in[NUM_DIGITS-1-g];
    assign blink_ord[g]                 = blink_in[NUM_DIGITS-1-g];
    assign an_tick_c[NUM_DIGITS-1-g]    = (sel_next_c != SEL_W'(g));
    assign an_cur_c[NUM_DIGITS-1-g]     = (digit_sel != SEL_W'(g));
  end

  // Inputs of the digit about to be selected; sampled only on a tick edge.
  assign slot_val_c   = dig_val[sel_next_c];
  assign slot_dp_c    = dp_ord[sel_next_c];
  assign slot_blank_c = blank_ord[sel_next_c];
  assign slot_blink_c = blink_ord[sel_next_c];

  // Slot pattern with blank over blink over decoded value.
  always_comb begin
    slot_pat_c = {~slot_dp_c, seg7_decode(slot_val_c, hex_mode)};
    if (slot_blank_c) begin
      slot_pat_c = SEG_DARK;
    end else if (slot_blink_c && blink_phase_q) begin
      slot_pat_c = SEG_DARK;
    end
  end

  // Next-state and next-output logic for the scan sequencer.
  always_comb begin
    state_nxt       = state_q;
    presc_nxt       = presc_q + PRESC_W'(1);
    sel_nxt         = digit_sel;
    frame_nxt       = frame_q;
    blink_phase_nxt = blink_phase_q;
    guard_nxt       = guard_q;
    an_nxt          = an_d;
    seg_nxt         = seg_d;

    if (tick_c) begin
      presc_nxt = '0;
      sel_nxt   = sel_next_c;
      seg_nxt   = slot_pat_c;
      if (wrap_c) begin
        if (frame_q == FRAME_MAX) begin
          frame_nxt       = '0;
          blink_phase_nxt = ~blink_phase_q;
        end else begin
          frame_nxt = frame_q + FRAME_W'(1);
        end
      end
      if (NO_GUARD) begin
        state_nxt = ST_DRIVE;
        guard_nxt = '0;
        an_nxt    = an_tick_c;
      end else begin
        state_nxt = ST_GUARD;
        guard_nxt = GUARD_LOAD;
        an_nxt    = '1;
      end
    end else begin
      case (state_q)
        ST_GUARD: begin
          if (guard_q <= GUARD_W'(1)) begin
            state_nxt = ST_DRIVE;
            guard_nxt = '0;
            an_nxt    = an_cur_c;
          end else begin
            guard_nxt = guard_q - GUARD_W'(1);
          end
        end
        ST_DARK, ST_DRIVE: begin
          state_nxt = state_q;
        end
        default: begin
          state_nxt = ST_DARK;
          an_nxt    = '1;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset to a dark display.
  always_ff @(posedge clk_m) begin
    if (!rst_n) begin
      state_q       <= ST_DARK;
      presc_q       <= '0;
      frame_q       <= '0;
      guard_q       <= '0;
      blink_phase_q <= 1'b0;
      digit_sel     <= LAST_DIG;
      an_d          <= '1;
      seg_d         <= SEG_DARK;
    end else begin
      state_q       <= state_nxt;
      presc_q       <= presc_nxt;
      frame_q       <= frame_nxt;
      guard_q       <= guard_nxt;
      blink_phase_q <= blink_phase_nxt;
      digit_sel     <= sel_nxt;
      an_d          <= an_nxt;
      seg_d         <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed scoreboard bench for seven_seg_scan_ctrl.
// Two instances share all inputs: one with a one-cycle guard, one with no guard.
module tb_seven_seg_scan_ctrl;

  logic        clk_m = 1'b0;
  logic        rst_n;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, blank_in, blink_in;
  logic        hex_mode;

  logic [3:0]  an_g1, an_g0;
  logic [7:0]  seg_g1, seg_g0;
  logic [1:0]  sel_g1, sel_g0;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] seg;
    logic [1:0] sel;
  } slot_t;

  slot_t sb[$];

  always #5 clk_m = ~clk_m;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .GUARD_CYC(1), .BLINK_DIV(2)
  ) dut_g1 (
    .clk_m(clk_m), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .blink_in(blink_in), .hex_mode(hex_mode),
    .an_d(an_g1), .seg_d(seg_g1), .digit_sel(sel_g1)
  );

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .GUARD_CYC(0), .BLINK_DIV(2)
  ) dut_g0 (
    .clk_m(clk_m), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .blink_in(blink_in), .hex_mode(hex_mode),
    .an_d(an_g0), .seg_d(seg_g0), .digit_sel(sel_g0)
  );

  // Reference glyph table with DP off.
  function automatic logic [7:0] ref_glyph(input logic [3:0] v, input logic hex);
    logic [7:0] r;
    case (v)
      4'h0: r = 8'hC0;
      4'h1: r = 8'hF9;
      4'h2: r = 8'hA4;
      4'h3: r = 8'hB0;
      4'h4: r = 8'h99;
      4'h5: r = 8'h92;
      4'h6: r = 8'h82;
      4'h7: r = 8'hF8;
      4'h8: r = 8'h80;
      4'h9: r = 8'h90;
      4'hA: r = hex ? 8'h88 : 8'hBF;
      4'hB: r = hex ? 8'h83 : 8'hBF;
      4'hC: r = hex ? 8'hC6 : 8'hBF;
      4'hD: r = hex ? 8'hA1 : 8'hBF;
      4'hE: r = hex ? 8'h86 : 8'hBF;
      default: r = hex ? 8'h8E : 8'hBF;
    endcase
    return r;
  endfunction

  // Expected anode pattern for a selected digit index.
  function automatic logic [3:0] exp_an(input logic [1:0] sel);
    logic [3:0] m;
    m = 4'b1000 >> sel;
    return ~m;
  endfunction

  // Push the expected pattern of digit i from the inputs currently driven.
  task automatic push_slot(input int i, input bit phase);
    slot_t      s;
    logic [15:0] d;
    logic [3:0]  dp_s, bl_s, bk_s;
    d    = digits_in << (4 * i);
    dp_s = dp_in << i;
    bl_s = blank_in << i;
    bk_s = blink_in << i;
    if (bl_s[3])              s.seg = 8'hFF;
    else if (bk_s[3] && phase) s.seg = 8'hFF;
    else begin
      s.seg = ref_glyph(d[15:12], hex_mode);
      if (dp_s[3]) s.seg[7] = 1'b0;
    end
    s.sel = 2'(i);
    sb.push_back(s);
  endtask

  task automatic push_frame(input bit phase);
    for (int i = 0; i < 4; i++) push_slot(i, phase);
  endtask

  task automatic chk(input string tag,
                     input logic [3:0] an, input logic [7:0] seg, input logic [1:0] sel,
                     input logic [3:0] ean, input logic [7:0] eseg, input logic [1:0] esel);
    vectors++;
    assert ({an, seg, sel} === {ean, eseg, esel}) else begin
      miscompares++;
      $error("FAIL %s: observed an=%b seg=%h sel=%0d, expected an=%b seg=%h sel=%0d",
             tag, an, seg, sel, ean, eseg, esel);
    end
  endtask

  // Reset for one edge, then check the three dark edges before the first tick.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    @(negedge clk_m);
    chk({tag, "_rst_g1"}, an_g1, seg_g1, sel_g1, 4'hF, 8'hFF, 2'd3);
    chk({tag, "_rst_g0"}, an_g0, seg_g0, sel_g0, 4'hF, 8'hFF, 2'd3);
    rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk_m);
      chk($sformatf("%s_dark%0d_g1", tag, e), an_g1, seg_g1, sel_g1, 4'hF, 8'hFF, 2'd3);
      chk($sformatf("%s_dark%0d_g0", tag, e), an_g0, seg_g0, sel_g0, 4'hF, 8'hFF, 2'd3);
    end
  endtask

  // Consume n slots from the scoreboard, checking tick, guard end and slot end.
  task automatic run_slots(input int n, input string tag);
    slot_t s;
    for (int k = 0; k < n; k++) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL %s: scoreboard empty, observed seg=%h, expected a queued slot", tag, seg_g1);
        return;
      end
      s = sb.pop_front();
      @(negedge clk_m);
      chk($sformatf("%s_tick_g1_d%0d", tag, s.sel), an_g1, seg_g1, sel_g1, 4'hF, s.seg, s.sel);
      chk($sformatf("%s_tick_g0_d%0d", tag, s.sel), an_g0, seg_g0, sel_g0, exp_an(s.sel), s.seg, s.sel);
      @(negedge clk_m);
      chk($sformatf("%s_on_g1_d%0d", tag, s.sel), an_g1, seg_g1, sel_g1, exp_an(s.sel), s.seg, s.sel);
      repeat (2) @(negedge clk_m);
      chk($sformatf("%s_end_g1_d%0d", tag, s.sel), an_g1, seg_g1, sel_g1, exp_an(s.sel), s.seg, s.sel);
      chk($sformatf("%s_end_g0_d%0d", tag, s.sel), an_g0, seg_g0, sel_g0, exp_an(s.sel), s.seg, s.sel);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion by %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    slot_t s;
    rst_n     = 1'b0;
    digits_in = 16'h1234;
    dp_in     = 4'b0000;
    blank_in  = 4'b0000;
    blink_in  = 4'b0000;
    hex_mode  = 1'b0;

    // Basic scan order, guard timing and wrap back to digit 0.
    do_reset("t1");
    push_frame(1'b0);
    push_frame(1'b0);
    run_slots(8, "t1");

    // Hex letters, then dashes for the same values.
    digits_in = 16'hABCF;
    hex_mode  = 1'b1;
    push_frame(1'b0);
    run_slots(4, "t2hex");
    hex_mode  = 1'b0;
    push_frame(1'b0);
    run_slots(4, "t2dash");

    // Decimal point and blanking; blanked slot keeps its anode.
    digits_in = 16'h8888;
    dp_in     = 4'b0100;
    blank_in  = 4'b0001;
    push_frame(1'b0);
    run_slots(4, "t3");

    // Blink on digit 0 with a two-frame half period.
    digits_in = 16'h0000;
    dp_in     = 4'b0000;
    blank_in  = 4'b0000;
    blink_in  = 4'b1000;
    do_reset("t4");
    for (int f = 0; f < 6; f++) begin
      push_frame(((f / 2) % 2) == 1);
      run_slots(4, $sformatf("t4f%0d", f));
    end

    // Mid-slot input change only shows at the next slot.
    blink_in = 4'b0000;
    push_slot(0, 1'b0);
    push_slot(1, 1'b0);
    push_slot(2, 1'b0);
    run_slots(2, "t5");
    s = sb.pop_front();
    @(negedge clk_m);
    chk("t5_d2_tick", an_g1, seg_g1, sel_g1, 4'hF, s.seg, s.sel);
    @(negedge clk_m);
    @(negedge clk_m);
    digits_in = 16'h9999;
    @(negedge clk_m);
    chk("t5_d2_hold", an_g1, seg_g1, sel_g1, exp_an(s.sel), s.seg, s.sel);
    push_slot(3, 1'b0);
    run_slots(1, "t5new");
    push_frame(1'b0);
    run_slots(4, "t5all");

    // Reset in the middle of digit 1's slot, then normal restart.
    digits_in = 16'h1234;
    push_frame(1'b0);
    run_slots(1, "t6pre");
    s = sb.pop_front();
    @(negedge clk_m);
    chk("t6_d1_tick", an_g1, seg_g1, sel_g1, 4'hF, s.seg, s.sel);
    @(negedge clk_m);
    chk("t6_d1_on", an_g1, seg_g1, sel_g1, 4'b1011, s.seg, s.sel);
    sb.delete();
    do_reset("t6");
    push_frame(1'b0);
    run_slots(4, "t6post");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
